det_nms_3x3: RTL and testbench
==============================

DET_NMS_3X3 -- requirements
Module: det_nms_3x3

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of the signed Hessian response (Q19.12, sign at MSB).
REQ-002 SHALL have parameter IMG_W, default 640, meaning pixels per row.
REQ-003 SHALL have parameter IMG_H, default 480, meaning rows per frame.
REQ-004 SHALL have parameter THRESH, default 32'sd4096 (1.0 in Q19.12), meaning the minimum response, compared strictly greater.
REQ-005 SHALL have port clk, input, 1, meaning the system clock.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, synchronous, active-low.
REQ-007 SHALL have port det_d_i, input, DATA_WIDTH, meaning the raster-order response sample from the determinant stage.
REQ-008 SHALL have port det_d_i_valid, input, 1, meaning the sample qualifier; gaps of any length are legal.
REQ-009 SHALL have port sof, input, 1, meaning start of frame, valid only together with det_d_i_valid on pixel (0,0).
REQ-010 SHALL have port kp_valid, output, 1, meaning a one-cycle keypoint strobe.
REQ-011 SHALL have ports kp_x and kp_y, output, $clog2(IMG_W) and $clog2(IMG_H), meaning the keypoint column and row.
REQ-012 SHALL have port kp_val, output, DATA_WIDTH, meaning the keypoint response value.
REQ-013 SHALL have port frame_done, output, 1, meaning a one-cycle pulse after the last pixel of a frame is accepted.
REQ-014 SHALL have port kp_cnt, output, 16, meaning the number of keypoints found in the current frame, saturating at 16'hFFFF.

Function
REQ-015 SHALL keep a column counter col and a row counter row that advance only on accepted samples.
- Wrap: col==IMG_W-1 sets col=0 and increments row.
REQ-016 SHALL use a two-state FSM, IDLE and ACTIVE.
- IDLE→ACTIVE on valid&&sof.
- ACTIVE→IDLE on acceptance of pixel (IMG_W-1, IMG_H-1); frame_done pulses on the next cycle.
REQ-017 SHALL ignore valid samples in IDLE that arrive without sof; no state change and no output.
REQ-018 SHALL restart on valid&&sof while ACTIVE: counters restart at (0,0), the in-flight window is discarded, and kp_cnt is cleared.
REQ-019 SHALL store the previous two rows in two IMG_W-deep line buffers and hold a 3x3 window of signed registers.
- The window shifts only on accepted samples.
REQ-020 SHALL evaluate a window when the accepted sample has col>=2 and row>=2; the candidate centre is (col-1, row-1).
REQ-021 SHALL declare a keypoint when:
- centre > THRESH, signed; and
- centre > each of the 8 neighbours, strictly and signed.
- Ties reject.
REQ-022 SHALL never report border pixels (x=0, x=IMG_W-1, y=0, y=IMG_H-1); windows that straddle the row wrap (col<2) SHALL be suppressed.
REQ-023 SHALL assert kp_valid exactly 2 clk cycles after the completing sample is accepted, independent of later input gaps, with kp_x, kp_y and kp_val stable in that cycle.
REQ-024 SHALL hold kp_x, kp_y and kp_val at zero when kp_valid=0.
REQ-025 SHALL increment kp_cnt in the cycle after each kp_valid and hold it until the next sof or reset.
REQ-026 SHALL have no back-pressure; the block accepts one sample per cycle at full rate.

Reset
REQ-027 SHALL, when rst_n=0 at a clk edge, set FSM=IDLE, col=row=0, clear the window registers, the pipeline valid flags, kp_valid, kp_x, kp_y, kp_val, frame_done and kp_cnt.
REQ-028 SHALL NOT clear line buffer RAM on reset; stale contents SHALL be masked by the row>=2 rule.
REQ-029 SHALL, on reset mid-frame, emit no kp_valid for in-flight windows and ignore input until the next sof.

Structure
REQ-030 SHALL place DATA_WIDTH, the default THRESH and the Q19.12 fraction-bit constant (12) in the shared package used by the determinant stage.
REQ-031 SHALL implement the line buffers as one sub-module, det_line_buf:
- simple dual-port, read-before-write, 1-cycle read latency;
- instantiated twice, or once with width 2*DATA_WIDTH.

Verification (IMG_W=8, IMG_H=6, THRESH=4096)
REQ-032 SHALL check that a frame of all-zero samples except 20000 at (3,2) gives exactly one kp_valid with (3,2,20000), 2 cycles after pixel (4,3) is accepted, and kp_cnt=1 after frame_done.
REQ-033 SHALL check that a peak of 20000 at (3,2) with 20000 also at (4,2) gives no kp_valid (tie).
REQ-034 SHALL check that a peak of 4096 at (3,2) gives no kp_valid, and 4097 gives one.
REQ-035 SHALL check that:
- a peak of -5 with neighbours -100 gives no kp_valid (threshold);
- peaks of 30000 at (0,2) and at (7,3) give no kp_valid (border).
REQ-036 SHALL check that random gaps of 0-5 cycles between samples give keypoint output identical to the gap-free run, with latency still 2 cycles.
REQ-037 SHALL check that sof asserted at pixel (5,3) mid-frame, or rst_n=0 for 1 cycle there, gives no stale kp_valid, kp_cnt=0, and a following clean frame that matches its golden model.

Source files
------------

// File: rtl/det_nms_3x3_pkg.sv
// Shared constants for the Hessian determinant / NMS path (Q19.12 responses).
package det_nms_3x3_pkg;

  localparam int DET_DATA_WIDTH = 32;
  localparam int DET_FRAC_BITS  = 12;
  localparam logic signed [31:0] DET_THRESH = 32'sd4096;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } nms_state_t;

endpackage

// File: rtl/det_line_buf.sv
// Simple dual-port row buffer: registered read, read-before-write on address collision.
module det_line_buf
  import det_nms_3x3_pkg::*;
#(
  parameter int WIDTH = 2 * DET_DATA_WIDTH,
  parameter int DEPTH = 640,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/det_nms_3x3.sv
// 3x3 non-maximum suppression on raster determinant responses: strict signed peak
// above threshold, interior pixels only, keypoint out two cycles after the completing sample.
module det_nms_3x3
  import det_nms_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = DET_DATA_WIDTH,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter logic signed [31:0] THRESH = DET_THRESH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     det_d_i,
  input  logic                      det_d_i_valid,
  input  logic                      sof,
  output logic                      kp_valid,
  output logic [$clog2(IMG_W)-1:0]  kp_x,
  output logic [$clog2(IMG_H)-1:0]  kp_y,
  output logic [DATA_WIDTH-1:0]     kp_val,
  output logic                      frame_done,
  output logic [15:0]               kp_cnt
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic signed [DATA_WIDTH-1:0] THR = DATA_WIDTH'(THRESH);

  nms_state_t state_reg;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;

  logic accept;
  logic restart;
  logic last_pix;
  logic [COL_W-1:0] pix_col;
  logic [ROW_W-1:0] pix_row;

  // A sof sample always starts a fresh frame at (0,0), whatever the counters say.
  assign restart  = det_d_i_valid && sof;
  assign accept   = det_d_i_valid && (sof || state_reg == ST_ACTIVE);
  assign pix_col  = restart ? '0 : col_reg;
  assign pix_row  = restart ? '0 : row_reg;
  assign last_pix = accept && !restart && col_reg == COL_LAST && row_reg == ROW_LAST;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      col_reg    <= '0;
      row_reg    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        if (pix_col == COL_LAST) begin
          col_reg <= '0;
          row_reg <= pix_row + ROW_W'(1);
        end else begin
          col_reg <= pix_col + COL_W'(1);
          row_reg <= pix_row;
        end
      end
      case (state_reg)
        ST_IDLE: begin
          if (restart) begin
            state_reg <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (last_pix) begin
            state_reg  <= ST_IDLE;
            frame_done <= 1'b1;
          end
        end
      endcase
    end
  end

  // Stage 1: sample and its position, waiting for the line-buffer read.
  logic                          s1_vld;
  logic signed [DATA_WIDTH-1:0]  s1_d;
  logic [COL_W-1:0]              s1_col;
  logic [ROW_W-1:0]              s1_row;

  // Line buffer word: {row-2, row-1} at the same column.
  logic [2*DATA_WIDTH-1:0] lb_q;
  logic [2*DATA_WIDTH-1:0] lb_wdata;

  // The write lands one cycle after the read so the shifted column comes from lb_q.
  assign lb_wdata = {lb_q[DATA_WIDTH-1:0], s1_d};

  det_line_buf #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (IMG_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (s1_vld),
    .wr_addr (s1_col),
    .wr_data (lb_wdata),
    .rd_en   (accept),
    .rd_addr (pix_col),
    .rd_data (lb_q)
  );

  // Window index r*3+c: r=0 oldest row, c=0 oldest column; centre is 4.
  logic signed [DATA_WIDTH-1:0] win_reg [9];
  logic                         s2_vld;
  logic [COL_W-1:0]             s2_x;
  logic [ROW_W-1:0]             s2_y;
  logic [8:0]                   gt;
  logic                         hit;

  for (genvar gi = 0; gi < 9; gi++) begin : g_cmp
    if (gi == 4) begin : g_thr
      assign gt[gi] = win_reg[4] > THR;
    end else begin : g_nb
      assign gt[gi] = win_reg[4] > win_reg[gi];
    end
  end

  assign hit = s2_vld && (&gt) && !restart;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_d     <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
      s2_vld   <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
      for (int i = 0; i < 9; i++) begin
        win_reg[i] <= '0;
      end
      kp_valid <= 1'b0;
      kp_x     <= '0;
      kp_y     <= '0;
      kp_val   <= '0;
      kp_cnt   <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_d   <= det_d_i;
        s1_col <= pix_col;
        s1_row <= pix_row;
      end

      // Windows with col<2 straddle the row wrap and rows<2 see stale RAM: never evaluate them.
      s2_vld <= s1_vld && !restart && (s1_col >= COL_W'(2)) && (s1_row >= ROW_W'(2));
      if (s1_vld) begin
        for (int r = 0; r < 3; r++) begin
          win_reg[r*3]     <= win_reg[r*3 + 1];
          win_reg[r*3 + 1] <= win_reg[r*3 + 2];
        end
        win_reg[2] <= lb_q[2*DATA_WIDTH-1:DATA_WIDTH];
        win_reg[5] <= lb_q[DATA_WIDTH-1:0];
        win_reg[8] <= s1_d;
        s2_x       <= s1_col - COL_W'(1);
        s2_y       <= s1_row - ROW_W'(1);
      end

      kp_valid <= hit;
      kp_x     <= hit ? s2_x : '0;
      kp_y     <= hit ? s2_y : '0;
      kp_val   <= hit ? win_reg[4] : '0;

      if (restart) begin
        kp_cnt <= '0;
      end else if (kp_valid && kp_cnt != 16'hFFFF) begin
        kp_cnt <= kp_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_det_nms_3x3.sv
// Randomized and directed bench for det_nms_3x3 against a frame-level peak model.
module tb_det_nms_3x3;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int THR = 4096;
  localparam int NPIX = W * H;
  localparam longint NO_ABORT = longint'(1) << 60;

  typedef struct {
    int     x;
    int     y;
    int     v;
    longint c;
  } kp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] det_d_i;
  logic        det_d_i_valid;
  logic        sof;
  logic        kp_valid;
  logic [2:0]  kp_x;
  logic [2:0]  kp_y;
  logic [31:0] kp_val;
  logic        frame_done;
  logic [15:0] kp_cnt;

  det_nms_3x3 #(
    .DATA_WIDTH (32),
    .IMG_W      (W),
    .IMG_H      (H),
    .THRESH     (32'sd4096)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .det_d_i       (det_d_i),
    .det_d_i_valid (det_d_i_valid),
    .sof           (sof),
    .kp_valid      (kp_valid),
    .kp_x          (kp_x),
    .kp_y          (kp_y),
    .kp_val        (kp_val),
    .frame_done    (frame_done),
    .kp_cnt        (kp_cnt)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     img [H][W];
  longint acc_cyc [H][W];
  kp_t    obs[$];
  kp_t    exp_q[$];
  kp_t    ref_q[$];
  int     fd_n;
  longint fd_cyc;
  int     zero_viol;
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    kp_t k;
    if (kp_valid) begin
      k.x = int'(kp_x);
      k.y = int'(kp_y);
      k.v = int'($signed(kp_val));
      k.c = cyc;
      obs.push_back(k);
      $display("kp x=%0d y=%0d val=%0d cyc=%0d", k.x, k.y, k.v, k.c);
    end else if (kp_x != 0 || kp_y != 0 || kp_val != 0) begin
      zero_viol++;
    end
    if (frame_done) begin
      fd_n++;
      fd_cyc = cyc;
    end
  end

  task automatic drive_pix(input int x, input int y, input logic s, input int gap_max);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      det_d_i_valid = 1'b0;
      sof           = 1'b0;
      det_d_i       = $urandom;
    end
    @(negedge clk);
    det_d_i       = img[y][x];
    det_d_i_valid = 1'b1;
    sof           = s;
    acc_cyc[y][x] = cyc + 1;
  endtask

  task automatic run_frame(input int gap_max, input int n_pix, input bit early_chk);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        acc_cyc[y][x] = -1;
    for (int i = 0; i < n_pix; i++) begin
      drive_pix(i % W, i / W, i == 0, gap_max);
      if (early_chk && i == 2) check_eq("restart_cnt_clr", kp_cnt, 0);
    end
  endtask

  // Peaks from the image itself; a keypoint appears 2 cycles after its window's last
  // pixel is accepted, unless the frame is aborted at or before that cycle.
  task automatic build_exp(input longint abort_c, output int n);
    int  c;
    bit  pk;
    kp_t k;
    n = 0;
    for (int y = 1; y < H - 1; y++) begin
      for (int x = 1; x < W - 1; x++) begin
        c  = img[y][x];
        pk = (c > THR);
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dy != 0 || dx != 0) && !(c > img[y+dy][x+dx])) pk = 1'b0;
        if (pk && acc_cyc[y+1][x+1] >= 0 && acc_cyc[y+1][x+1] + 2 < abort_c) begin
          k.x = x;
          k.y = y;
          k.v = c;
          k.c = acc_cyc[y+1][x+1] + 2;
          exp_q.push_back(k);
          n++;
        end
      end
    end
  endtask

  task automatic start_scn();
    obs.delete();
    exp_q.delete();
    fd_n      = 0;
    zero_viol = 0;
  endtask

  task automatic fill_img(input int base);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = base;
  endtask

  task automatic rand_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = int'($urandom_range(40000, 0)) - 20000;
  endtask

  task automatic finish_scn(input string tag, input int fd_exp, input int cnt_exp);
    @(negedge clk);
    det_d_i_valid = 1'b0;
    sof           = 1'b0;
    repeat (6) @(negedge clk);
    check_eq({tag, "_kp_n"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      check_eq({tag, "_kp_x"},   obs[i].x, exp_q[i].x);
      check_eq({tag, "_kp_y"},   obs[i].y, exp_q[i].y);
      check_eq({tag, "_kp_val"}, obs[i].v, exp_q[i].v);
      check_eq({tag, "_kp_cyc"}, obs[i].c, exp_q[i].c);
    end
    check_eq({tag, "_fd_n"}, fd_n, fd_exp);
    if (fd_exp == 1) check_eq({tag, "_fd_cyc"}, fd_cyc, acc_cyc[H-1][W-1]);
    check_eq({tag, "_kp_cnt"}, kp_cnt, cnt_exp);
    check_eq({tag, "_idle_zero"}, zero_viol, 0);
    $display("scenario %s: %0d keypoints observed", tag, obs.size());
  endtask

  task automatic directed(input string tag, input int n_kp_exp);
    int n;
    start_scn();
    run_frame(0, NPIX, 1'b0);
    build_exp(NO_ABORT, n);
    finish_scn(tag, 1, n);
    check_eq({tag, "_const_n"}, obs.size(), n_kp_exp);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    longint abort_c;
    rst_n         = 1'b0;
    det_d_i       = '0;
    det_d_i_valid = 1'b0;
    sof           = 1'b0;
    fd_n          = 0;
    zero_viol     = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_kp_valid",   kp_valid, 0);
    check_eq("rst_kp_cnt",     kp_cnt, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_kp_x",       kp_x, 0);
    check_eq("rst_kp_val",     kp_val, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single peak: (3,2,20000), completing pixel (4,3), count 1.
    fill_img(0);
    img[2][3] = 20000;
    directed("single", 1);
    if (obs.size() > 0) begin
      check_eq("single_x",   obs[0].x, 3);
      check_eq("single_y",   obs[0].y, 2);
      check_eq("single_val", obs[0].v, 20000);
      check_eq("single_lat", obs[0].c - acc_cyc[3][4], 2);
    end
    check_eq("single_cnt", kp_cnt, 1);

    fill_img(0);
    img[2][3] = 20000;
    img[2][4] = 20000;
    directed("tie", 0);

    fill_img(0);
    img[2][3] = 4096;
    directed("at_thresh", 0);

    fill_img(0);
    img[2][3] = 4097;
    directed("above_thresh", 1);

    fill_img(-100);
    img[2][3] = -5;
    directed("negative", 0);

    fill_img(0);
    img[2][0] = 30000;
    img[3][7] = 30000;
    directed("border", 0);

    // Same random frame without and with input gaps.
    rand_img();
    start_scn();
    run_frame(0, NPIX, 1'b0);
    build_exp(NO_ABORT, n);
    finish_scn("rand_nogap", 1, n);
    ref_q = obs;
    start_scn();
    run_frame(5, NPIX, 1'b0);
    build_exp(NO_ABORT, n);
    finish_scn("rand_gap", 1, n);
    check_eq("gap_vs_nogap_n", obs.size(), ref_q.size());
    for (int i = 0; i < obs.size() && i < ref_q.size(); i++) begin
      check_eq("gap_vs_nogap_x", obs[i].x, ref_q[i].x);
      check_eq("gap_vs_nogap_y", obs[i].y, ref_q[i].y);
      check_eq("gap_vs_nogap_v", obs[i].v, ref_q[i].v);
    end

    // Frame aborted by sof at (5,3): (1,1) already emitted, (3,2) in flight.
    fill_img(0);
    img[1][1] = 20000;
    img[2][3] = 20000;
    start_scn();
    run_frame(0, 3 * W + 5, 1'b0);
    abort_c = acc_cyc[3][4] + 1;
    build_exp(abort_c, n);
    rand_img();
    run_frame(0, NPIX, 1'b1);
    build_exp(NO_ABORT, n);
    finish_scn("restart_sof", 1, n);

    // Frame aborted by a one-cycle reset at (5,3), then non-sof samples that must be ignored.
    fill_img(0);
    img[1][1] = 20000;
    img[2][3] = 20000;
    start_scn();
    run_frame(0, 3 * W + 5, 1'b0);
    abort_c = acc_cyc[3][4] + 1;
    build_exp(abort_c, n);
    @(negedge clk);
    rst_n         = 1'b0;
    det_d_i       = 32'd30000;
    det_d_i_valid = 1'b1;
    sof           = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      det_d_i       = (i % 3 == 1) ? 32'd25000 : 32'd0;
      det_d_i_valid = 1'b1;
      sof           = 1'b0;
    end
    check_eq("reset_cnt_clr", kp_cnt, 0);
    rand_img();
    run_frame(0, NPIX, 1'b0);
    build_exp(NO_ABORT, n);
    finish_scn("restart_rst", 1, n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
